uart_rx_frontend: RTL and testbench
===================================

// Module: uart_rx_frontend
// PURPOSE
//  Serial-to-parallel UART receiver feeding the CPU's memory-mapped UART RX data/status registers.
//  Sits directly upstream of the core: the board/bench serial_in pin enters here.
//  Frames are 8N1, LSB first; the received byte is handed over on a ready/valid port.
//  Framing errors and overruns are reported to the CPU's status register.
// PARAMETERS
//  CLOCK_FREQ  50_000_000  core clock in Hz (20 ns period)
//  BAUD_RATE   115_200     line rate in baud
//  (derived) SYMBOL_EDGE_TIME = CLOCK_FREQ/BAUD_RATE, SAMPLE_TIME = SYMBOL_EDGE_TIME/2
//  (derived) CNT_W = $clog2(SYMBOL_EDGE_TIME)
// PORTS
//  clk             in   1  core clock, all state on posedge
//  rst_n           in   1  asynchronous active-low reset
//  serial_in       in   1  asynchronous RX line, idle high
//  data_out        out  8  received byte, stable while data_out_valid=1
//  data_out_valid  out  1  byte available
//  data_out_ready  in   1  CPU consumes byte (MMIO read of RX data)
//  framing_error   out  1  one-cycle pulse: stop bit sampled low
//  overrun         out  1  sticky: a completed byte was dropped
//  overrun_clr     in   1  clears overrun (MMIO write)
//  rx_busy         out  1  high while FSM not in IDLE
// BEHAVIOUR
//  Reset (async, rst_n=0): FSM=IDLE, sync flops=1, shift reg=0, counters=0.
//   data_out=0, data_out_valid=0, framing_error=0, overrun=0, rx_busy=0.
//   Reset mid-frame aborts the frame; no partial byte is ever presented.
//  Input: 2-flop synchronizer, reset value 1; all decisions use the synchronized bit rx_s.
//  FSM states IDLE, START, DATA, STOP:
//   IDLE : rx_s==0 -> START, clk_cnt<=0.
//   START: clk_cnt==SAMPLE_TIME-1 -> sample rx_s. 1 -> IDLE (glitch rejected). 0 -> DATA, clk_cnt<=0, bit_cnt<=0.
//   DATA : clk_cnt==SYMBOL_EDGE_TIME-1 -> shift rx_s in at MSB (LSB-first line order), bit_cnt++, clk_cnt<=0.
//          After 8th bit -> STOP.
//   STOP : clk_cnt==SYMBOL_EDGE_TIME-1 -> sample rx_s, return to IDLE that cycle.
//          Returning at mid-stop allows back-to-back frames.
//          rx_s==1 -> byte complete. rx_s==0 -> framing_error=1 for exactly 1 cycle; byte discarded.
//  Latency: data_out_valid rises 2 sync cycles + 9*SYMBOL_EDGE_TIME + SAMPLE_TIME cycles after the start edge (+/-1).
//  Handshake:
//   - A transfer occurs when data_out_valid && data_out_ready on a posedge.
//   - data_out_valid stays 1 and data_out stays stable until that transfer; then valid drops next cycle.
//   - data_out_ready while valid=0 has no effect.
//  Byte completes while valid=1 and ready=0: new byte dropped, old data kept, overrun<=1.
//  Byte completes in the same cycle as a transfer: new byte loaded, valid stays 1, no overrun.
//  overrun stays set until overrun_clr=1. If overrun_clr coincides with a new overrun, set wins.
//  Counters never wrap silently: clk_cnt is zeroed at every symbol boundary; bit_cnt is 0..7 only.
// STRUCTURE
//  Shared package uart_pkg:
//   - rx_state_t enum {IDLE, START, DATA, STOP}
//   - UART_DATA_W=8
//   - function symbol_edge_time(clock_freq, baud_rate)
//  Sub-module sync_2ff (reset-to-1 two-flop synchronizer) instantiated once.
//  FSM, counters, shift reg and output holding register live in this module.
// TESTING (bench: CLOCK_FREQ=1_000_000, BAUD_RATE=100_000 -> 10 cycles/bit)
//  1. Send 0xA5, ready held 1 -> data_out=0xA5, valid high exactly 1 cycle, framing_error=0, overrun=0.
//  2. Send 0x3C, ready=0 for 200 cycles, then 0xC3 -> data_out stays 0x3C, overrun=1.
//     Ready pulse -> valid=0; overrun_clr -> overrun=0.
//  3. Send 0x55 with stop bit driven 0 -> framing_error one-cycle pulse, valid stays 0.
//     Next good frame 0x0F -> received correctly.
//  4. 3-cycle low glitch on idle line -> FSM returns to IDLE, no valid, no error, rx_busy back to 0.
//  5. Back-to-back frames 0x01, 0xFE with no idle gap, ready=1 -> both received in order.
//  6. Assert rst_n=0 during bit 4 of 0x99 -> all outputs 0 immediately; after release, next frame 0x42 received.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

  localparam int unsigned UART_DATA_W = 8;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } rx_state_t;

  // Core clock cycles per line symbol.
  function automatic int unsigned symbol_edge_time(input int unsigned clock_freq,
                                                   input int unsigned baud_rate);
    return clock_freq / baud_rate;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, resets to 1 (idle line level).
module sync_2ff (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back capture stages; the first may go metastable.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_frontend.sv
// 8N1 UART receiver: samples mid-symbol, hands bytes over on a ready/valid port and
// reports framing errors (pulse) and overruns (sticky) for the CPU status register.
module uart_rx_frontend
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ = 50_000_000,
  parameter int unsigned BAUD_RATE  = 115_200
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   serial_in,
  output logic [UART_DATA_W-1:0] data_out,
  output logic                   data_out_valid,
  input  logic                   data_out_ready,
  output logic                   framing_error,
  output logic                   overrun,
  input  logic                   overrun_clr,
  output logic                   rx_busy
);

  localparam int unsigned SymbolEdgeTime = symbol_edge_time(CLOCK_FREQ, BAUD_RATE);
  localparam int unsigned SampleTime     = SymbolEdgeTime / 2;
  localparam int unsigned CntW           = $clog2(SymbolEdgeTime);

  localparam logic [CntW-1:0] SymLast    = CntW'(SymbolEdgeTime - 1);
  localparam logic [CntW-1:0] SampleLast = CntW'(SampleTime - 1);

  logic rx_s;

  rx_state_t              state_q, state_d;
  logic [CntW-1:0]        clk_cnt_q, clk_cnt_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [UART_DATA_W-1:0] shift_q, shift_d;
  logic [UART_DATA_W-1:0] data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   fe_q, fe_d;
  logic                   ovr_q, ovr_d;

  logic start_hit, bit_hit, stop_hit;
  logic byte_done, xfer;

  sync_2ff u_sync (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .d_i    (serial_in),
    .q_o    (rx_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (!rx_s) state_d = StStart;
      StStart: if (clk_cnt_q == SampleLast) state_d = rx_s ? StIdle : StData;
      StData:  if (clk_cnt_q == SymLast && bit_cnt_q == 3'd7) state_d = StStop;
      StStop:  if (clk_cnt_q == SymLast) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs: busy flag and the per-state sampling strobes.
  always_comb begin
    rx_busy   = (state_q != StIdle);
    start_hit = (state_q == StStart) && (clk_cnt_q == SampleLast);
    bit_hit   = (state_q == StData) && (clk_cnt_q == SymLast);
    stop_hit  = (state_q == StStop) && (clk_cnt_q == SymLast);
  end

  // Datapath next state: counters, shifter, output holding register and status flags.
  always_comb begin
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = valid_q;
    ovr_d     = ovr_q;

    // Counter restarts at every sampling point so it never wraps on its own.
    if (state_q == StIdle || start_hit || bit_hit || stop_hit) begin
      clk_cnt_d = '0;
    end else begin
      clk_cnt_d = clk_cnt_q + 1'b1;
    end

    if (start_hit) begin
      bit_cnt_d = 3'd0;
    end else if (bit_hit) begin
      bit_cnt_d = bit_cnt_q + 3'd1;
      shift_d   = {rx_s, shift_q[UART_DATA_W-1:1]};
    end

    byte_done = stop_hit && rx_s;
    fe_d      = stop_hit && !rx_s;
    xfer      = valid_q && data_out_ready;

    if (xfer) valid_d = 1'b0;

    // A completing byte replaces the held one only if the slot is free or being emptied.
    if (byte_done) begin
      if (!valid_q || xfer) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end
    end

    // Set beats clear when both happen together.
    if (byte_done && valid_q && !xfer) begin
      ovr_d = 1'b1;
    end else if (overrun_clr) begin
      ovr_d = 1'b0;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      fe_q      <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      fe_q      <= fe_d;
      ovr_q     <= ovr_d;
    end
  end

  assign data_out       = data_q;
  assign data_out_valid = valid_q;
  assign framing_error  = fe_q;
  assign overrun        = ovr_q;

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Scoreboard bench for uart_rx_frontend at 10 clocks per bit.
module tb_uart_rx_frontend;

  localparam int unsigned BitCycles = 10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       serial_in;
  logic [7:0] data_out;
  logic       data_out_valid;
  logic       data_out_ready;
  logic       framing_error;
  logic       overrun;
  logic       overrun_clr;
  logic       rx_busy;

  int         checks = 0;
  int         errors = 0;
  int         valid_cycles = 0;
  int         fe_expect = 0;
  logic [7:0] exp_q[$];

  uart_rx_frontend #(
    .CLOCK_FREQ (1_000_000),
    .BAUD_RATE  (100_000)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .serial_in      (serial_in),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready),
    .framing_error  (framing_error),
    .overrun        (overrun),
    .overrun_clr    (overrun_clr),
    .rx_busy        (rx_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change 2 ns after the rising edge; outputs are observed on the falling edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    serial_in = 1'b0;
    repeat (BitCycles) tick();
    for (int i = 0; i < 8; i++) begin
      serial_in = b[i];
      repeat (BitCycles) tick();
    end
    serial_in = stop_bit;
    repeat (BitCycles) tick();
    serial_in = 1'b1;
  endtask

  // Monitor: every handshake must match the oldest expected byte; every error pulse must be expected.
  always @(negedge clk) begin
    if (rst_n) begin
      if (data_out_valid) valid_cycles++;
      if (data_out_valid && data_out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got 0x%0h expected none at %0t", data_out, $time);
        end else begin
          check("rx_byte", {24'd0, data_out}, {24'd0, exp_q.pop_front()});
        end
      end
      if (framing_error) begin
        checks++;
        if (fe_expect == 0) begin
          errors++;
          $display("FAIL unexpected_framing_error: got 1 expected 0 at %0t", $time);
        end else begin
          fe_expect--;
        end
      end
    end
  end

  initial begin
    int vc0;
    rst_n          = 1'b0;
    serial_in      = 1'b1;
    data_out_ready = 1'b0;
    overrun_clr    = 1'b0;
    #1;
    check("reset_data",  {24'd0, data_out}, 32'h0);
    check("reset_valid", {31'd0, data_out_valid}, 32'h0);
    check("reset_fe",    {31'd0, framing_error}, 32'h0);
    check("reset_ovr",   {31'd0, overrun}, 32'h0);
    check("reset_busy",  {31'd0, rx_busy}, 32'h0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (5) tick();

    // 1: single byte, ready held high.
    data_out_ready = 1'b1;
    vc0 = valid_cycles;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    repeat (5) tick();
    check("t1_valid_cycles", 32'(valid_cycles - vc0), 32'd1);
    check("t1_fe",  {31'd0, framing_error}, 32'h0);
    check("t1_ovr", {31'd0, overrun}, 32'h0);

    // 2: overrun while the first byte is held.
    data_out_ready = 1'b0;
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    repeat (200) tick();
    send_frame(8'hC3, 1'b1);
    repeat (5) tick();
    check("t2_data_held", {24'd0, data_out}, 32'h3C);
    check("t2_valid",     {31'd0, data_out_valid}, 32'h1);
    check("t2_ovr_set",   {31'd0, overrun}, 32'h1);
    data_out_ready = 1'b1;
    tick();
    data_out_ready = 1'b0;
    tick();
    check("t2_valid_drop",  {31'd0, data_out_valid}, 32'h0);
    check("t2_ovr_sticky",  {31'd0, overrun}, 32'h1);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    check("t2_ovr_clr", {31'd0, overrun}, 32'h0);

    // 3: framing error, then a clean frame.
    data_out_ready = 1'b1;
    fe_expect++;
    send_frame(8'h55, 1'b0);
    repeat (30) tick();
    check("t3_no_valid", {31'd0, data_out_valid}, 32'h0);
    exp_q.push_back(8'h0F);
    send_frame(8'h0F, 1'b1);
    repeat (5) tick();

    // 4: short glitch is rejected.
    serial_in = 1'b0;
    repeat (3) tick();
    serial_in = 1'b1;
    repeat (2) tick();
    check("t4_busy_during", {31'd0, rx_busy}, 32'h1);
    repeat (20) tick();
    check("t4_busy_after", {31'd0, rx_busy}, 32'h0);
    check("t4_no_valid",   {31'd0, data_out_valid}, 32'h0);

    // 5: back-to-back frames.
    exp_q.push_back(8'h01);
    exp_q.push_back(8'hFE);
    send_frame(8'h01, 1'b1);
    send_frame(8'hFE, 1'b1);
    repeat (10) tick();

    // 6: reset in the middle of a frame, held until the line is idle again.
    fork
      send_frame(8'h99, 1'b1);
      begin
        repeat (BitCycles * 5 + 5) tick();
        rst_n = 1'b0;
        #1;
        check("t6_busy",  {31'd0, rx_busy}, 32'h0);
        check("t6_valid", {31'd0, data_out_valid}, 32'h0);
        check("t6_data",  {24'd0, data_out}, 32'h0);
        check("t6_fe",    {31'd0, framing_error}, 32'h0);
        check("t6_ovr",   {31'd0, overrun}, 32'h0);
      end
    join
    repeat (5) tick();
    rst_n = 1'b1;
    repeat (5) tick();
    exp_q.push_back(8'h42);
    send_frame(8'h42, 1'b1);
    repeat (10) tick();

    check("all_bytes_seen",    32'(exp_q.size()), 32'd0);
    check("all_errors_seen",   32'(fe_expect), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
